// File: rtl/spi_rx_packetizer.sv
// Frames the MISO bytes of one SPI transaction into a host-bound packet:
// SOF, TYPE, LEN, data (padded with 00 on timeout), STATUS, CHK.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | waiting for the CTRL start write; rx bytes discarded
//  S_SOF    | presenting SOF_BYTE
//  S_TYPE   | presenting TYPE_SPI
//  S_LEN    | presenting exp_len; skips to S_STATUS when exp_len is 0
//  S_DATA   | streaming buffered rx bytes; idle timer runs while buffer empty
//  S_PAD    | presenting 00 for every byte that never arrived
//  S_STATUS | presenting {6'b0, overflow, timeout}
//  S_CHK    | presenting XOR of TYPE..STATUS, then back to S_IDLE
module spi_rx_packetizer #(
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter logic [7:0]  SOF_BYTE            = 8'hA5,
  parameter logic [7:0]  TYPE_SPI            = 8'h03,
  parameter int unsigned TIMEOUT_CYCLES      = 100000,
  parameter logic [15:0] SPI_BASE_ADDR       = 16'h0400,
  parameter logic [15:0] SPI_REG_OFFSET_CTRL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_write,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [15:0]   CTRL_ADDR = SPI_BASE_ADDR + SPI_REG_OFFSET_CTRL;
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_TYPE, S_LEN, S_DATA, S_PAD, S_STATUS, S_CHK
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    exp_len_q, exp_len_d;
  logic [8:0]    sent_cnt_q, sent_cnt_d;
  logic [8:0]    rcv_cnt_q, rcv_cnt_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d, fifo_rem;
  logic [7:0]    head_d;

  logic arm, fire, rx_window, fifo_full, fifo_empty;
  logic push, pop, ovf_set, tmo_run, tmo_fire, last_byte;
  logic unused_wdata;

  assign unused_wdata = ^{cfg_wdata[31:16], cfg_wdata[7:1]};

  assign arm        = cfg_write && (cfg_addr == CTRL_ADDR) && cfg_wdata[0] && (state_q == S_IDLE);
  assign fire       = tx_valid_q && tx_ready;
  assign fifo_full  = (fifo_cnt_q == FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign rx_window  = (state_q != S_IDLE) && (state_q != S_PAD) && (rcv_cnt_q < {1'b0, exp_len_q});
  assign pop        = fire && (state_q == S_DATA);
  // A byte arriving on a full buffer still fits when the head leaves the same cycle.
  assign push       = rx_valid && rx_window && (!fifo_full || pop);
  assign ovf_set    = rx_valid && rx_window && fifo_full && !pop;
  assign last_byte  = (sent_cnt_q + 9'd1) == {1'b0, exp_len_q};
  assign tmo_run    = (state_q == S_DATA) && fifo_empty && (sent_cnt_q < {1'b0, exp_len_q});
  assign tmo_fire   = tmo_run && !push && (tmo_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    exp_len_d  = exp_len_q;
    sent_cnt_d = sent_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    overflow_d = overflow_q | ovf_set;
    timeout_d  = timeout_q | tmo_fire;
    chk_d      = chk_q;
    tmo_cnt_d  = tmo_cnt_q;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

    unique case (state_q)
      S_IDLE:   if (arm) state_d = S_SOF;
      S_SOF:    if (fire) state_d = S_TYPE;
      S_TYPE:   if (fire) state_d = S_LEN;
      S_LEN:    if (fire) state_d = (exp_len_q == 8'd0) ? S_STATUS : S_DATA;
      S_DATA: begin
        if (fire && last_byte) state_d = S_STATUS;
        else if (tmo_fire)     state_d = S_PAD;
      end
      S_PAD:    if (fire && last_byte) state_d = S_STATUS;
      S_STATUS: if (fire) state_d = S_CHK;
      S_CHK:    if (fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (push) rcv_cnt_d = rcv_cnt_q + 9'd1;
    if (fire && (state_q == S_DATA || state_q == S_PAD)) sent_cnt_d = sent_cnt_q + 9'd1;
    if (fire && state_q != S_SOF && state_q != S_CHK && state_q != S_IDLE)
      chk_d = chk_q ^ tx_data_q;

    if (!tmo_run || push || fire) tmo_cnt_d = TMO_LOAD;
    else if (tmo_cnt_q != '0)     tmo_cnt_d = tmo_cnt_q - TW'(1);

    if (arm) begin
      exp_len_d  = cfg_wdata[15:8];
      sent_cnt_d = '0;
      rcv_cnt_d  = '0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
      chk_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  // Next head of the buffer; an empty buffer being written forwards the incoming byte.
  always_comb begin
    fifo_rem = fifo_cnt_q - CW'(pop);
    head_d   = mem[rd_ptr_d];
    if (fifo_rem == '0) head_d = rx_data;
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (!(tx_valid_q && !tx_ready)) begin
      unique case (state_d)
        S_IDLE:   begin tx_valid_d = 1'b0; tx_data_d = 8'h00; end
        S_SOF:    begin tx_valid_d = 1'b1; tx_data_d = SOF_BYTE; end
        S_TYPE:   begin tx_valid_d = 1'b1; tx_data_d = TYPE_SPI; end
        S_LEN:    begin tx_valid_d = 1'b1; tx_data_d = exp_len_d; end
        S_DATA: begin
          tx_valid_d = (fifo_cnt_d != '0);
          tx_data_d  = (fifo_cnt_d != '0) ? head_d : 8'h00;
        end
        S_PAD:    begin tx_valid_d = 1'b1; tx_data_d = 8'h00; end
        S_STATUS: begin tx_valid_d = 1'b1; tx_data_d = {6'b0, overflow_d, timeout_d}; end
        S_CHK:    begin tx_valid_d = 1'b1; tx_data_d = chk_d; end
        default:  begin tx_valid_d = 1'b0; tx_data_d = 8'h00; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      exp_len_q  <= '0;
      sent_cnt_q <= '0;
      rcv_cnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      chk_q      <= '0;
      tmo_cnt_q  <= TMO_LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      exp_len_q  <= exp_len_d;
      sent_cnt_q <= sent_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      chk_q      <= chk_d;
      tmo_cnt_q  <= tmo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_data;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_rx_packetizer.sv
// Randomized bench for spi_rx_packetizer; expected frames are built from the
// packet format rules (accepted bytes, zero pads, status flags, XOR checksum).
module tb_spi_rx_packetizer;

  localparam int          DEPTH = 16;
  localparam int          TMO   = 16;
  localparam logic [15:0] BASE  = 16'h0400;
  localparam logic [15:0] OFF   = 16'h0010;
  localparam logic [15:0] CTRL  = BASE + OFF;
  localparam logic [7:0]  SOF   = 8'hA5;
  localparam logic [7:0]  TYP   = 8'h03;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_write;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] acc_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  spi_rx_packetizer #(
    .FIFO_DEPTH(DEPTH), .SOF_BYTE(SOF), .TYPE_SPI(TYP), .TIMEOUT_CYCLES(TMO),
    .SPI_BASE_ADDR(BASE), .SPI_REG_OFFSET_CTRL(OFF)
  ) dut (
    .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_write(cfg_write), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake recorder plus hold-under-stall check, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== data_prev) begin
          errors++;
          $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h", tx_valid, tx_data, data_prev);
        end
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_t.push_back(cyc);
      end
      stall_prev = tx_valid && !tx_ready;
      data_prev  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [15:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_write = 1'b1;
    tick();
    cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
  endtask

  task automatic arm(input logic [7:0] len);
    cfg_wr(CTRL, {16'h0, len, 8'h01});
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    tx_ready = 1'b1;
  endtask

  // Expected frame: accepted bytes, zero pads for the rest, flags, XOR checksum.
  task automatic build_expect(input int len, input bit ovf);
    logic [7:0] c;
    bit tmo;
    exp_q = {};
    exp_q.push_back(SOF);
    exp_q.push_back(TYP);
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) exp_q.push_back(i < acc_q.size() ? acc_q[i] : 8'h00);
    tmo = (acc_q.size() < len);
    exp_q.push_back({6'b0, ovf, tmo});
    c = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) c ^= exp_q[i];
    exp_q.push_back(c);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_addr = '0; cfg_wdata = '0; cfg_write = 1'b0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b valid=%b exp 0 0", busy, tx_valid); end
  endtask

  task automatic test_basic();
    bit ok;
    int len;
    for (int it = 0; it < 4; it++) begin
      acc_q = {};
      if (it == 0) begin
        len = 3; acc_q.push_back(8'h12); acc_q.push_back(8'h34); acc_q.push_back(8'h56);
      end else begin
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) acc_q.push_back(8'($urandom));
      end
      got_q = {}; got_t = {};
      tx_ready = 1'b1;
      arm(8'(len));
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== SOF || busy !== 1'b1) begin
        errors++; $display("FAIL basic_sof_latency got valid=%b data=%h busy=%b exp 1 %h 1", tx_valid, tx_data, busy, SOF);
      end
      for (int i = 0; i < len; i++) begin
        send(acc_q[i]);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_done(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done got busy=%b exp 0", busy); end
      build_expect(len, 1'b0);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (overflow !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL basic_end got ovf=%b valid=%b exp 0 0", overflow, tx_valid); end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    acc_q = {}; got_q = {}; got_t = {};
    tx_ready = 1'b1;
    arm(8'd0);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_done got busy=%b exp 0", busy); end
    build_expect(0, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL zero_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 3; i++) send(8'($urandom));
    cfg_wr(CTRL, 32'h0000_0500);
    cfg_wr(CTRL + 16'h4, 32'h0000_0501);
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL zero_idle_ignore got busy=%b valid=%b exp 0 0", busy, tx_valid); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL zero_no_extra got %0d exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    acc_q = {8'hAB}; got_q = {}; got_t = {};
    tx_ready = 1'b1;
    arm(8'd2);
    send(8'hAB);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_done got busy=%b exp 0", busy); end
    build_expect(2, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tmo_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    if (got_t.size() >= 5) begin
      checks++;
      if (got_t[4] - got_t[3] != TMO + 1) begin
        errors++; $display("FAIL tmo_pad_delay got %0d exp %0d", got_t[4] - got_t[3], TMO + 1);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    acc_q = {}; got_q = {}; got_t = {};
    tx_ready = 1'b0;
    arm(8'd20);
    for (int i = 1; i <= 20; i++) begin
      send(8'(i));
      if (i <= DEPTH) acc_q.push_back(8'(i));
    end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== SOF) begin errors++; $display("FAIL ovf_hdr_hold got %b %h exp 1 %h", tx_valid, tx_data, SOF); end
    tx_ready = 1'b1;
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done got busy=%b exp 0", busy); end
    build_expect(20, 1'b1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_stall_random();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      acc_q = {}; got_q = {}; got_t = {};
      for (int i = 0; i < 8; i++) acc_q.push_back(8'($urandom));
      tx_ready = 1'b0;
      arm(8'd8);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_ovf_clear got %b exp 0", overflow); end
      for (int i = 0; i < 8; i++) begin
        tx_ready = 1'($urandom_range(0, 1));
        send(acc_q[i]);
        repeat ($urandom_range(0, 3)) begin tx_ready = 1'($urandom_range(0, 1)); tick(); end
      end
      wait_done(1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_done got busy=%b exp 0", busy); end
      build_expect(8, 1'b0);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    acc_q = {}; got_q = {}; got_t = {};
    for (int i = 0; i < 4; i++) acc_q.push_back(8'($urandom));
    tx_ready = 1'b1;
    arm(8'd4);
    send(acc_q[0]);
    send(acc_q[1]);
    arm(8'd9);
    send(acc_q[2]);
    send(acc_q[3]);
    wait_done(1'b0, ok);
    checks++; if (!ok || tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got ok=%b valid=%b exp 1 0", ok, tx_valid); end
    build_expect(4, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    acc_q = {8'($urandom), 8'($urandom)}; got_q = {}; got_t = {};
    arm(8'd2);
    checks++; if (tx_valid !== 1'b1 || tx_data !== SOF) begin errors++; $display("FAIL b2b_rearm got %b %h exp 1 %h", tx_valid, tx_data, SOF); end
    send(acc_q[0]);
    send(acc_q[1]);
    wait_done(1'b0, ok);
    build_expect(2, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b2_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b2_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] d [3];
    foreach (d[i]) d[i] = 8'($urandom);
    tx_ready = 1'b0;
    arm(8'd6);
    foreach (d[i]) send(d[i]);
    tx_ready = 1'b1;
    repeat (4) tick();
    tx_ready = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== d[1]) begin errors++; $display("FAIL mid_data got %b %h exp 1 %h", tx_valid, tx_data, d[1]); end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_reset got valid=%b busy=%b data=%h exp 0 0 00", tx_valid, busy, tx_data); end
    tick();
    rst = 1'b0;
    tick();
    acc_q = {8'($urandom), 8'($urandom)}; got_q = {}; got_t = {};
    tx_ready = 1'b1;
    arm(8'd2);
    send(acc_q[0]);
    send(acc_q[1]);
    wait_done(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_done got busy=%b exp 0", busy); end
    build_expect(2, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_timeout();
    test_overflow();
    test_stall_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
